wb_mem_arbiter: RTL and testbench

Two-master Wishbone B3 arbiter that shares the single external RAM slave (`wb_ram`) between the ao486 CPU memory master and a secondary master (DMA / debug loader). It sits between `ao486_cpu_wb_wrapper`'s memory port and `wb_ram`. Grants are round-robin, locked for the duration of `cyc`, so bursts and read-modify-write sequences are never split. A per-grant watchdog terminates stalled cycles with an error.

---
 rtl/wb_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone B3 arbiter in front of the shared RAM slave: round-robin grant
// held for the whole cyc, plus a per-grant watchdog that aborts stalled cycles with err.
module wb_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     wbm0_adr_i,
  input  logic [DW-1:0]     wbm0_dat_i,
  input  logic [DW/8-1:0]   wbm0_sel_i,
  input  logic              wbm0_we_i,
  input  logic              wbm0_cyc_i,
  input  logic              wbm0_stb_i,
  input  logic [2:0]        wbm0_cti_i,
  input  logic [1:0]        wbm0_bte_i,
  output logic [DW-1:0]     wbm0_dat_o,
  output logic              wbm0_ack_o,
  output logic              wbm0_err_o,
  output logic              wbm0_rty_o,
  input  logic [AW-1:0]     wbm1_adr_i,
  input  logic [DW-1:0]     wbm1_dat_i,
  input  logic [DW/8-1:0]   wbm1_sel_i,
  input  logic              wbm1_we_i,
  input  logic              wbm1_cyc_i,
  input  logic              wbm1_stb_i,
  input  logic [2:0]        wbm1_cti_i,
  input  logic [1:0]        wbm1_bte_i,
  output logic [DW-1:0]     wbm1_dat_o,
  output logic              wbm1_ack_o,
  output logic              wbm1_err_o,
  output logic              wbm1_rty_o,
  output logic [AW-1:0]     wbs_adr_o,
  output logic [DW-1:0]     wbs_dat_o,
  output logic [DW/8-1:0]   wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  input  logic [DW-1:0]     wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i,
  output logic [1:0]        gnt_o
);

  localparam int unsigned       CW       = 16;
  localparam logic [CW-1:0]     TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1, S_ABORT} state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_who;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_gnt;

  logic w_g0;
  logic w_g1;
  logic w_granted;
  logic w_cyc;
  logic w_stb;
  logic w_resp;
  logic w_timeout;

  assign w_g0      = (r_state == S_GNT0);
  assign w_g1      = (r_state == S_GNT1);
  assign w_granted = w_g0 | w_g1;
  assign w_cyc     = r_who ? wbm1_cyc_i : wbm0_cyc_i;
  assign w_stb     = r_who ? wbm1_stb_i : wbm0_stb_i;
  assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A slave response in the expiry cycle wins over the watchdog.
  assign w_timeout = w_granted & w_cyc & w_stb & ~w_resp & ~wb_rst_i & (r_cnt == TMO_LAST);

  // Request path: master 1 only while it holds the grant, otherwise master 0.
  assign wbs_adr_o = w_g1 ? wbm1_adr_i : wbm0_adr_i;
  assign wbs_dat_o = w_g1 ? wbm1_dat_i : wbm0_dat_i;
  assign wbs_sel_o = w_g1 ? wbm1_sel_i : wbm0_sel_i;
  assign wbs_cti_o = w_g1 ? wbm1_cti_i : wbm0_cti_i;
  assign wbs_bte_o = w_g1 ? wbm1_bte_i : wbm0_bte_i;
  assign wbs_we_o  = w_granted & (w_g1 ? wbm1_we_i : wbm0_we_i);
  assign wbs_cyc_o = w_granted & w_cyc & ~w_timeout;
  assign wbs_stb_o = w_granted & w_stb & ~w_timeout;

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = w_g0 & wbs_ack_i;
  assign wbm0_err_o = w_g0 & (wbs_err_i | w_timeout);
  assign wbm0_rty_o = w_g0 & wbs_rty_i;
  assign wbm1_ack_o = w_g1 & wbs_ack_i;
  assign wbm1_err_o = w_g1 & (wbs_err_i | w_timeout);
  assign wbm1_rty_o = w_g1 & wbs_rty_i;

  assign gnt_o = r_gnt;

  // Grant FSM with round-robin tie-break and the stall watchdog.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_who   <= 1'b0;
      r_cnt   <= '0;
      r_gnt   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (wbm0_cyc_i && (!wbm1_cyc_i || r_last)) begin
            r_state <= S_GNT0;
            r_who   <= 1'b0;
            r_gnt   <= 2'b01;
          end else if (wbm1_cyc_i) begin
            r_state <= S_GNT1;
            r_who   <= 1'b1;
            r_gnt   <= 2'b10;
          end
        end
        S_GNT0, S_GNT1: begin
          if (!w_cyc) begin
            r_state <= S_IDLE;
            r_last  <= r_who;
            r_gnt   <= 2'b00;
          end else if (w_timeout) begin
            r_state <= S_ABORT;
            r_gnt   <= 2'b00;
          end else if (w_resp) begin
            r_cnt <= '0;
          end else if (w_stb) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ABORT: begin
          if (!w_cyc) begin
            r_state <= S_IDLE;
            r_last  <= r_who;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed vector table, hand-written burst/timeout/reset
// sequences, then random traffic against an ownership-based reference model.
module tb_wb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic          m_we  [2];
  logic          m_cyc [2];
  logic          m_stb [2];
  logic [2:0]    m_cti [2];
  logic [1:0]    m_bte [2];
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty;

  logic [DW-1:0] wbm0_dat_o, wbm1_dat_o;
  logic          wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
  logic          wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [SW-1:0] wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [1:0]    gnt_o;

  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_sel_i(m_sel[0]), .wbm0_we_i(m_we[0]),
    .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]), .wbm0_cti_i(m_cti[0]), .wbm0_bte_i(m_bte[0]),
    .wbm0_dat_o(wbm0_dat_o), .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o), .wbm0_rty_o(wbm0_rty_o),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_sel_i(m_sel[1]), .wbm1_we_i(m_we[1]),
    .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]), .wbm1_cti_i(m_cti[1]), .wbm1_bte_i(m_bte[1]),
    .wbm1_dat_o(wbm1_dat_o), .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o), .wbm1_rty_o(wbm1_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who owns the slave, whether that ownership was aborted,
  // who was served last, and how many stalled strobe cycles have elapsed.
  int owner    = -1;
  bit aborting = 1'b0;
  int last_m   = 1;
  int waited   = 0;
  bit mdl_tmo  = 1'b0;

  int n_ack0 = 0;
  int n_ack1 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Let inputs settle, then compare every DUT output against the model.
  task automatic settle();
    bit granted;
    bit resp;
    int o;
    int k;
    logic [75:0] exp_req;
    logic [75:0] act_req;
    logic [1:0]  exp_gnt;
    #1;
    granted = (owner >= 0) && !aborting;
    o       = (owner < 0) ? 0 : owner;
    resp    = s_ack || s_err || s_rty;
    mdl_tmo = granted && m_cyc[o] && m_stb[o] && !resp && (waited == int'(TMO) - 1) && !rst;
    k       = (granted && owner == 1) ? 1 : 0;
    exp_req = {m_adr[k], m_dat[k], m_sel[k], granted && m_we[k],
               granted && m_cyc[o] && !mdl_tmo, granted && m_stb[o] && !mdl_tmo,
               m_cti[k], m_bte[k]};
    act_req = {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o};
    exp_gnt = !granted ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
    check("slave_req", 128'(act_req), 128'(exp_req));
    check("m0_resp", 128'({wbm0_ack_o, wbm0_err_o, wbm0_rty_o}),
          128'({granted && owner == 0 && s_ack, granted && owner == 0 && (s_err || mdl_tmo),
                granted && owner == 0 && s_rty}));
    check("m1_resp", 128'({wbm1_ack_o, wbm1_err_o, wbm1_rty_o}),
          128'({granted && owner == 1 && s_ack, granted && owner == 1 && (s_err || mdl_tmo),
                granted && owner == 1 && s_rty}));
    check("rd_data", 128'({wbm0_dat_o, wbm1_dat_o}), 128'({s_dat, s_dat}));
    check("gnt", 128'(gnt_o), 128'(exp_gnt));
    n_ack0 += int'(wbm0_ack_o);
    n_ack1 += int'(wbm1_ack_o);
  endtask

  // Advance the model on the coming edge, then move to just after it.
  task automatic tick();
    bit resp;
    resp = s_ack || s_err || s_rty;
    if (rst) begin
      owner = -1; aborting = 1'b0; last_m = 1; waited = 0;
    end else if (owner < 0) begin
      waited = 0;
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last_m;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
    end else if (!m_cyc[owner]) begin
      last_m = owner; owner = -1; aborting = 1'b0;
    end else if (!aborting) begin
      if (mdl_tmo)             aborting = 1'b1;
      else if (resp)           waited = 0;
      else if (m_stb[owner])   waited++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  typedef struct packed {
    logic       rst, c0, c1, ack;
    logic [1:0] gnt;
    logic       ack0, ack1, scyc;
  } vec_t;

  vec_t tbl [19];
  int   err_at;
  int   n_errp;

  initial begin
    // rst c0 c1 ack | gnt ack0 ack1 scyc
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 2; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '1; m_we[k] = 1'b0;
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_cti[k] = 3'b000; m_bte[k] = 2'b00;
    end
    m_adr[0] = 32'h01FF_FFF0;
    s_dat = 32'hEB03_EB03; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    // Directed vectors: single read, tie from reset, alternating ties.
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;
      m_cyc[0] = tbl[i].c0; m_stb[0] = tbl[i].c0;
      m_cyc[1] = tbl[i].c1; m_stb[1] = tbl[i].c1;
      s_ack = tbl[i].ack;
      settle();
      check("tbl_gnt", 128'(gnt_o), 128'(tbl[i].gnt));
      check("tbl_ack", 128'({wbm0_ack_o, wbm1_ack_o}), 128'({tbl[i].ack0, tbl[i].ack1}));
      check("tbl_scyc", 128'(wbs_cyc_o), 128'(tbl[i].scyc));
      if (tbl[i].ack0) check("tbl_dat0", 128'(wbm0_dat_o), 128'(32'hEB03_EB03));
      if (tbl[i].ack1) check("tbl_dat1", 128'(wbm1_dat_o), 128'(32'hEB03_EB03));
      tick();
    end

    // Master 0 incrementing burst while master 1 waits.
    s_ack = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010; m_adr[0] = 32'h0000_1000;
    step();
    n_ack0 = 0; n_ack1 = 0;
    for (int b = 0; b < 4; b++) begin
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      m_adr[0] = 32'h0000_1000 + 32'(4 * b);
      m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      settle();
      if (b == 3) check("burst_cti_end", 128'(wbs_cti_o), 128'(3'b111));
      tick();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = 3'b000; s_ack = 1'b0;
    step();
    step();
    check("burst_acks_m0", 128'(n_ack0), 128'(4));
    check("burst_acks_m1", 128'(n_ack1), 128'(0));
    s_ack = 1'b1;
    settle();
    check("m1_ack_after_burst", 128'(wbm1_ack_o), 128'(1'b1));
    tick();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
    step();

    // Watchdog: slave never answers master 0.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    err_at = -1; n_errp = 0;
    for (int i = 1; i <= 14; i++) begin
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      settle();
      if (wbm0_err_o) begin
        n_errp++;
        if (err_at < 0) err_at = i;
      end
      if (i == 12) begin
        check("abort_gnt", 128'(gnt_o), 128'(2'b00));
        check("abort_scyc", 128'(wbs_cyc_o), 128'(1'b0));
      end
      tick();
    end
    check("tmo_err_cycle", 128'(err_at), 128'(8));
    check("tmo_err_pulses", 128'(n_errp), 128'(1));
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    step();
    settle();
    check("post_abort_gnt1", 128'(gnt_o), 128'(2'b10));
    tick();

    // Reset during master 1's write.
    m_we[1] = 1'b1;
    step();
    rst = 1'b1;
    step();
    s_ack = 1'b1;
    settle();
    check("rst_scyc", 128'(wbs_cyc_o), 128'(1'b0));
    check("rst_gnt", 128'(gnt_o), 128'(2'b00));
    check("rst_resp", 128'({wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o}), 128'(4'b0000));
    tick();
    rst = 1'b0; s_ack = 1'b0; m_we[1] = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_cyc[k]) begin
          if ($urandom_range(9) == 0) m_cyc[k] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          m_cyc[k] = 1'b1;
        end
        m_stb[k] = m_cyc[k] && ($urandom_range(3) != 0);
        m_adr[k] = $urandom;
        m_dat[k] = $urandom;
        m_sel[k] = SW'($urandom);
        m_we[k]  = 1'($urandom);
        m_cti[k] = 3'($urandom);
        m_bte[k] = 2'($urandom);
      end
      begin
        int r;
        r = int'($urandom_range(15));
        s_ack = (r < 2);
        s_err = (r == 2);
        s_rty = (r == 3);
      end
      s_dat = $urandom;
      rst   = ($urandom_range(199) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
